// File: rtl/fs_en_pkg.sv
// rtl/fs_en_pkg.sv - shared types and constants for the sample-rate enable generator
package fs_en_pkg;

  localparam int FS_CNT_WIDTH  = 16;
  localparam int DEF_ACC_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_RUN,
    ST_STOP
  } fs_en_state_t;

endpackage

// File: rtl/fs_en_gen_if.sv
// rtl/fs_en_gen_if.sv - control/strobe bundle between a controller and fs_en_gen
interface fs_en_gen_if
  import fs_en_pkg::*;
#(
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
);

  logic                    run;
  logic [ACC_WIDTH-1:0]    fcw_in;
  logic                    fcw_load;
  logic                    fcw_ack;
  logic                    fs_en;
  logic                    fs_en2;
  logic                    fs_en_div2;
  logic [FS_CNT_WIDTH-1:0] sample_cnt;
  logic                    busy;

  modport master (
    output run, fcw_in, fcw_load,
    input  fcw_ack, fs_en, fs_en2, fs_en_div2, sample_cnt, busy
  );

  modport slave (
    input  run, fcw_in, fcw_load,
    output fcw_ack, fs_en, fs_en2, fs_en_div2, sample_cnt, busy
  );

endinterface

// File: rtl/fs_en_nco.sv
// rtl/fs_en_nco.sv - phase accumulator, strobe register and FCW shadow/apply logic
module fs_en_nco
  import fs_en_pkg::*;
#(
  parameter int                   ACC_WIDTH = DEF_ACC_WIDTH,
  parameter logic [ACC_WIDTH-1:0] INIT_FCW  = 32'h4000_0000
) (
  input  logic                 clk0,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 step,
  input  logic                 idle,
  input  logic                 fcw_load,
  input  logic [ACC_WIDTH-1:0] fcw_in,
  output logic                 carry,
  output logic                 strobe,
  output logic                 fs_en,
  output logic                 fcw_ack
);

  logic [ACC_WIDTH-1:0] acc_q;
  logic [ACC_WIDTH-1:0] fcw_active_q;
  logic [ACC_WIDTH-1:0] fcw_shadow_q;
  logic                 pending_q;
  logic                 fs_en_q;
  logic                 fcw_ack_q;
  logic [ACC_WIDTH:0]   sum;
  logic                 apply;

  assign sum    = {1'b0, acc_q} + {1'b0, fcw_active_q};
  assign carry  = sum[ACC_WIDTH];
  assign strobe = start | (step & carry);
  // A new FCW only takes effect on a strobe edge so no period is ever shortened.
  assign apply  = pending_q & (idle | strobe);

  always_ff @(posedge clk0) begin
    if (!rst_n) begin
      acc_q        <= '0;
      fcw_active_q <= INIT_FCW;
      fcw_shadow_q <= '0;
      pending_q    <= 1'b0;
      fs_en_q      <= 1'b0;
      fcw_ack_q    <= 1'b0;
    end else begin
      if (start) begin
        acc_q <= fcw_active_q;
      end else if (step) begin
        acc_q <= sum[ACC_WIDTH-1:0];
      end
      fs_en_q   <= strobe;
      fcw_ack_q <= apply;
      if (apply) begin
        fcw_active_q <= fcw_shadow_q;
      end
      // A load on the apply edge lets the older value go active and keeps the new one pending.
      if (fcw_load) begin
        fcw_shadow_q <= fcw_in;
        pending_q    <= 1'b1;
      end else if (apply) begin
        pending_q <= 1'b0;
      end
    end
  end

  assign fs_en   = fs_en_q;
  assign fcw_ack = fcw_ack_q;

endmodule

// File: rtl/fs_en_gen.sv
// rtl/fs_en_gen.sv - NCO-based sample enable generator with fs/2 and fs/4 square waves
module fs_en_gen
  import fs_en_pkg::*;
#(
  parameter int                   ACC_WIDTH = DEF_ACC_WIDTH,
  parameter logic [ACC_WIDTH-1:0] INIT_FCW  = 32'h4000_0000
) (
  input  logic        clk0,
  input  logic        rst_n,
  fs_en_gen_if.slave  bus
);

  fs_en_state_t            state_q;
  fs_en_state_t            state_d;
  logic                    nco_start;
  logic                    nco_step;
  logic                    carry;
  logic                    strobe;
  logic                    fs_en2_q;
  logic                    div2_q;
  logic [FS_CNT_WIDTH-1:0] cnt_q;

  fs_en_nco #(
    .ACC_WIDTH (ACC_WIDTH),
    .INIT_FCW  (INIT_FCW)
  ) u_nco (
    .clk0     (clk0),
    .rst_n    (rst_n),
    .start    (nco_start),
    .step     (nco_step),
    .idle     (state_q == ST_IDLE),
    .fcw_load (bus.fcw_load),
    .fcw_in   (bus.fcw_in),
    .carry    (carry),
    .strobe   (strobe),
    .fs_en    (bus.fs_en),
    .fcw_ack  (bus.fcw_ack)
  );

  always_ff @(posedge clk0) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    nco_start = 1'b0;
    nco_step  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.run) state_d = ST_START;
      end
      ST_START: begin
        nco_start = 1'b1;
        state_d   = ST_RUN;
      end
      ST_RUN, ST_STOP: begin
        // With fs_en2 already low a stop needs no closing strobe.
        if (!bus.run && !fs_en2_q) begin
          state_d = ST_IDLE;
        end else begin
          nco_step = 1'b1;
          if (bus.run)   state_d = ST_RUN;
          else if (carry) state_d = ST_IDLE;
          else           state_d = ST_STOP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk0) begin
    if (!rst_n) begin
      fs_en2_q <= 1'b0;
      div2_q   <= 1'b0;
      cnt_q    <= '0;
    end else if (strobe) begin
      fs_en2_q <= ~fs_en2_q;
      if (fs_en2_q) div2_q <= ~div2_q;
      cnt_q <= nco_start ? FS_CNT_WIDTH'(1) : cnt_q + 1'b1;
    end
  end

  assign bus.fs_en2     = fs_en2_q;
  assign bus.fs_en_div2 = div2_q;
  assign bus.sample_cnt = cnt_q;
  assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fs_en_gen.sv
// tb/tb_fs_en_gen.sv - directed and randomized bench for fs_en_gen against a rate model
module tb_fs_en_gen;

  localparam longint MOD = 64'h1_0000_0000;
  localparam int M_IDLE = 0, M_START = 1, M_RUN = 2, M_STOP = 3;

  logic clk0 = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk0 = ~clk0;

  fs_en_gen_if #(.ACC_WIDTH(32)) bus ();

  fs_en_gen #(
    .ACC_WIDTH (32),
    .INIT_FCW  (32'h4000_0000)
  ) dut (
    .clk0  (clk0),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int n_ack = 0;
  int ack_cyc = 0;
  int strobes[$];
  int fs2_rise[$];
  int div2_rise[$];
  logic prev_fs2 = 1'b0;
  logic prev_div2 = 1'b0;

  int     m_mode = M_IDLE;
  longint m_phase = 0;
  longint m_fcw = 64'h4000_0000;
  longint m_shadow = 0;
  bit     m_pend = 0, m_fs_en = 0, m_fs2 = 0, m_div2 = 0, m_ack = 0, m_busy = 0;
  int     m_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  function automatic logic [20:0] dut_vec();
    return {bus.fs_en, bus.fs_en2, bus.fs_en_div2, bus.fcw_ack, bus.busy, bus.sample_cnt};
  endfunction

  // Reference: phase advances by fcw each running cycle, a wrap past 2^32 is a sample.
  task automatic model_edge();
    longint sum;
    bit wrap, strobe, apply;
    int nxt;
    if (!rst_n) begin
      m_mode = M_IDLE; m_phase = 0; m_fcw = 64'h4000_0000; m_pend = 0;
      m_fs_en = 0; m_fs2 = 0; m_div2 = 0; m_ack = 0; m_busy = 0; m_cnt = 0;
      return;
    end
    sum = m_phase + m_fcw;
    wrap = (sum >= MOD);
    strobe = 0;
    nxt = m_mode;
    if (m_mode == M_IDLE) begin
      if (bus.run) nxt = M_START;
    end else if (m_mode == M_START) begin
      m_phase = m_fcw; strobe = 1; nxt = M_RUN;
    end else if (!bus.run && !m_fs2) begin
      nxt = M_IDLE;
    end else begin
      m_phase = sum % MOD;
      strobe = wrap;
      nxt = bus.run ? M_RUN : (wrap ? M_IDLE : M_STOP);
    end
    apply = m_pend && (m_mode == M_IDLE || strobe);
    m_ack = apply;
    if (apply) m_fcw = m_shadow;
    if (bus.fcw_load) begin
      m_shadow = longint'(bus.fcw_in); m_pend = 1;
    end else if (apply) m_pend = 0;
    m_fs_en = strobe;
    if (strobe) begin
      m_cnt = (m_mode == M_START) ? 1 : (m_cnt + 1) % 65536;
      if (m_fs2) m_div2 = !m_div2;
      m_fs2 = !m_fs2;
    end
    m_mode = nxt;
    m_busy = (nxt != M_IDLE);
  endtask

  task automatic step();
    @(posedge clk0);
    model_edge();
    #1;
    cyc++;
    chk("cycle", 64'(dut_vec()), 64'({m_fs_en, m_fs2, m_div2, m_ack, m_busy, 16'(m_cnt)}));
    if (bus.fs_en) strobes.push_back(cyc);
    if (bus.fcw_ack) begin n_ack++; ack_cyc = cyc; end
    if (bus.fs_en2 && !prev_fs2) fs2_rise.push_back(cyc);
    if (bus.fs_en_div2 && !prev_div2) div2_rise.push_back(cyc);
    prev_fs2 = bus.fs_en2;
    prev_div2 = bus.fs_en_div2;
  endtask

  initial begin
    int start_c, p;
    bus.run = 1'b0; bus.fcw_load = 1'b0; bus.fcw_in = '0; rst_n = 1'b0;
    step(); step();
    chk("reset_outputs", 64'(dut_vec()), 64'd0);
    rst_n = 1'b1;
    step();

    // Start at the reset rate of a quarter of clk0.
    bus.run = 1'b1;
    step();
    start_c = cyc;
    chk("start_busy", 64'(bus.busy), 64'd1);
    strobes.delete(); fs2_rise.delete(); div2_rise.delete();
    repeat (40) step();
    chk("first_strobe", 64'(strobes[0]), 64'(start_c + 1));
    for (int i = 2; i < strobes.size(); i++) chk("init_spacing", 64'(strobes[i] - strobes[i-1]), 64'd4);
    chk("fs2_period", 64'(fs2_rise[$] - fs2_rise[$-1]), 64'd8);
    chk("div2_period", 64'(div2_rise[$] - div2_rise[$-1]), 64'd16);

    // Two loads before the next strobe: one ack, last value wins.
    for (int i = 0; i < 8 && !bus.fs_en; i++) step();
    bus.fcw_in = 32'h2000_0000; bus.fcw_load = 1'b1; step();
    bus.fcw_in = 32'h8000_0000; step();
    bus.fcw_load = 1'b0;
    n_ack = 0; strobes.delete();
    repeat (12) step();
    chk("single_ack", 64'(n_ack), 64'd1);
    chk("ack_at_strobe", 64'(ack_cyc), 64'(strobes[0]));
    for (int i = 1; i < strobes.size(); i++) chk("half_rate_spacing", 64'(strobes[i] - strobes[i-1]), 64'd2);

    // Stop with fs_en2 high: one closing strobe.
    for (int i = 0; i < 8 && !bus.fs_en2; i++) step();
    bus.run = 1'b0; strobes.delete();
    for (int i = 0; i < 20 && bus.busy; i++) step();
    chk("stop_one_strobe", 64'(strobes.size()), 64'd1);
    chk("stop_fs2_low", 64'(bus.fs_en2), 64'd0);
    chk("stop_idle", 64'(bus.busy), 64'd0);

    // Stop with fs_en2 low: nothing further.
    bus.run = 1'b1; step(); step();
    for (int i = 0; i < 8 && bus.fs_en2; i++) step();
    bus.run = 1'b0; strobes.delete();
    repeat (10) step();
    chk("stop_low_no_strobe", 64'(strobes.size()), 64'd0);
    chk("stop_low_idle", 64'(bus.busy), 64'd0);

    // Fractional 3/8 rate.
    bus.fcw_in = 32'h6000_0000; bus.fcw_load = 1'b1; step();
    bus.fcw_load = 1'b0; step();
    bus.run = 1'b1; step(); step();
    strobes.delete();
    repeat (64) step();
    chk("frac_24_per_64", 64'(strobes.size()), 64'd24);
    for (int i = 3; i < strobes.size(); i++) chk("frac_3_per_8", 64'(strobes[i] - strobes[i-3]), 64'd8);
    bus.run = 1'b0;
    for (int i = 0; i < 30 && bus.busy; i++) step();

    // Re-run during STOP keeps the cadence and the count.
    bus.fcw_in = 32'h4000_0000; bus.fcw_load = 1'b1; step();
    bus.fcw_load = 1'b0; step();
    bus.run = 1'b1;
    repeat (6) step();
    for (int i = 0; i < 12 && !(bus.fs_en && bus.fs_en2); i++) step();
    p = cyc;
    bus.run = 1'b0; step();
    chk("in_stop_busy", 64'(bus.busy), 64'd1);
    bus.run = 1'b1; strobes.delete();
    repeat (20) step();
    chk("rerun_strobes", 64'(strobes.size()), 64'd5);
    chk("rerun_first_gap", 64'(strobes[0] - p), 64'd4);
    for (int i = 1; i < strobes.size(); i++) chk("rerun_spacing", 64'(strobes[i] - strobes[i-1]), 64'd4);

    // Reset mid-run discards a pending FCW.
    for (int i = 0; i < 8 && !bus.fs_en; i++) step();
    bus.fcw_in = 32'h1000_0000; bus.fcw_load = 1'b1; step();
    bus.fcw_load = 1'b0; rst_n = 1'b0; step();
    chk("midrun_reset", 64'(dut_vec()), 64'd0);
    rst_n = 1'b1; n_ack = 0; strobes.delete();
    repeat (24) step();
    chk("no_ack_after_reset", 64'(n_ack), 64'd0);
    for (int i = 2; i < strobes.size(); i++) chk("init_restored", 64'(strobes[i] - strobes[i-1]), 64'd4);

    // Random run/load/reset traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(15) == 0) bus.run = ~bus.run;
      bus.fcw_load = ($urandom_range(19) == 0);
      case ($urandom_range(4))
        0: bus.fcw_in = 32'h0;
        1: bus.fcw_in = 32'hFFFF_FFFF;
        2: bus.fcw_in = 32'h8000_0000;
        3: bus.fcw_in = $urandom >> $urandom_range(8);
        default: bus.fcw_in = $urandom;
      endcase
      rst_n = ($urandom_range(499) != 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
